gated_stream_rx: RTL

// - Receive side of the predicate-gated datapath. The producer stage emits (pred, data) and

---
 rtl/gated_stream_rx.sv | 115 +++++++++++
 1 files changed

// File: rtl/gated_stream_rx.sv
// gated_stream_rx: receive side of the predicate-gated datapath; drops gated
// (pred=0) items, forwards live items through a 2-stage registered pipeline.
// Ports: clk, rst (sync, active-high); in_valid/in_pred/in_data/in_ready
// (upstream handshake); out_valid/out_data/out_ready (downstream handshake);
// drop_cnt (saturating dropped-item count); gate_err (sticky gate breach).
// Optional: define GATED_STREAM_RX_ASSERT_EN to emit protocol assertions.
module gated_stream_rx #(
  parameter int DATA_W     = 1,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_pred,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  gate_err
);

  logic                  s0_valid_q, s0_valid_d;
  logic                  s0_pred_q, s0_pred_d;
  logic [DATA_W-1:0]     s0_data_q, s0_data_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]     s1_data_q, s1_data_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic                  gate_err_q, gate_err_d;

  logic s1_load;
  logic s0_adv;
  logic accept;
  logic drop;

  assign s1_load  = !s1_valid_q | out_ready;
  // A gated item never needs s1, so it leaves s0 unconditionally.
  assign s0_adv   = s0_valid_q & (!s0_pred_q | s1_load);
  assign in_ready = !s0_valid_q | s0_adv;
  assign accept   = in_valid & in_ready;
  assign drop     = s0_adv & !s0_pred_q;

  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_pred_d  = s0_pred_q;
    s0_data_d  = s0_data_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    drop_cnt_d = drop_cnt_q;
    gate_err_d = gate_err_q;

    if (accept) begin
      s0_valid_d = 1'b1;
      s0_pred_d  = in_pred;
      s0_data_d  = in_data;
    end else if (s0_adv) begin
      s0_valid_d = 1'b0;
    end

    if (s0_adv & s0_pred_q) begin
      s1_valid_d = 1'b1;
      s1_data_d  = s0_data_q;
    end else if (out_ready) begin
      s1_valid_d = 1'b0;
    end

    if (drop) begin
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
      if (s0_data_q != '0) begin
        gate_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_pred_q  <= 1'b0;
      s0_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      drop_cnt_q <= '0;
      gate_err_q <= 1'b0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_pred_q  <= s0_pred_d;
      s0_data_q  <= s0_data_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      drop_cnt_q <= drop_cnt_d;
      gate_err_q <= gate_err_d;
    end
  end

  assign out_valid = s1_valid_q;
  assign out_data  = s1_data_q;
  assign drop_cnt  = drop_cnt_q;
  assign gate_err  = gate_err_q;

`ifdef GATED_STREAM_RX_ASSERT_EN
  gate_invariant: assert property (
    @(posedge clk) disable iff (rst)
    !(in_valid & in_ready & !in_pred) | (in_data == '0)
  );

  out_stable: assert property (
    @(posedge clk) disable iff (rst)
    out_valid & !out_ready |=> out_valid & $stable(out_data)
  );
`endif

endmodule
